// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage refill controller.
package mem_pkg;
  typedef enum logic [2:0] {IDLE, RD_WAIT, FILL, REPLAY, WR_WAIT} refill_state_t;

  localparam int BLOCK_OFFSET_BITS = 3;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 15;
  localparam int WR_LAT_MIN = 1;
  localparam int WR_LAT_MAX = 15;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst)                    q_q <= '0;
    else if (inc && (q_q != '1)) q_q <= q_q + WIDTH'(1);
  end

  assign q = q_q;
endmodule

// File: rtl/mem_refill_ctrl.sv
// Memory-stage sequencer: stalls for load-miss refills and write-through stores,
// drives the cache fill port and keeps saturating hit/miss counters.
module mem_refill_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memReadM,
  input  logic                  memWriteM,
  input  logic                  hitM,
  input  logic [DATA_WIDTH-1:0] aluResultM,
  output logic                  stallM,
  output logic                  fillEn,
  output logic [DATA_WIDTH-1:0] fillAddr,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  missCnt,
  output logic [CNT_WIDTH-1:0]  hitCnt
);
  localparam logic       ST_HOLDS = (WRITE_LATENCY > 1);
  localparam logic [3:0] RD_CNT   = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_CNT   = 4'((WRITE_LATENCY > 1) ? WRITE_LATENCY - 2 : 0);

  refill_state_t         state_q;
  logic [3:0]            cnt_q;
  logic [DATA_WIDTH-1:0] fill_addr_q;
  logic                  ld_miss, ld_hit, idle, stall;
  logic                  unused_offset;

  assign ld_miss       = memReadM & ~memWriteM & ~hitM;
  assign ld_hit        = memReadM & ~memWriteM &  hitM;
  assign idle          = (state_q == IDLE);
  assign unused_offset = ^aluResultM[BLOCK_OFFSET_BITS-1:0];

  // The detect cycle counts as the first latency cycle, so RD_WAIT lasts
  // READ_LATENCY-1 cycles and FILL lands exactly READ_LATENCY cycles after detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fill_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (memWriteM) begin
            if (ST_HOLDS) begin
              cnt_q   <= WR_CNT;
              state_q <= WR_WAIT;
            end
          end else if (ld_miss) begin
            fill_addr_q <= {aluResultM[DATA_WIDTH-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
            cnt_q       <= RD_CNT;
            state_q     <= (READ_LATENCY == 1) ? FILL : RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt_q <= 4'd1) state_q <= FILL;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        FILL:    state_q <= REPLAY;
        REPLAY:  state_q <= IDLE;
        WR_WAIT: begin
          if (cnt_q == 4'd0) state_q <= IDLE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Last WR_WAIT cycle releases the pipeline so the held store retires
  // instead of being re-detected in IDLE.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:          stall = memWriteM ? ST_HOLDS : ld_miss;
      RD_WAIT, FILL: stall = 1'b1;
      WR_WAIT:       stall = (cnt_q != 4'd0);
      default:       stall = 1'b0;
    endcase
  end

  assign stallM   = stall & ~rst;
  assign fillEn   = (state_q == FILL) & ~rst;
  assign fillAddr = fill_addr_q;
  assign busy     = ~idle;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk (clk),
    .rst (rst),
    .inc (idle & ld_miss),
    .q   (missCnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (idle & ld_hit),
    .q   (hitCnt)
  );
endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Scoreboard bench: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_mem_refill_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b1, wr = 1'b0, hit = 1'b0;
  logic [31:0] addr = 32'h0000_1234;

  logic        stallM, fillEn, busy;
  logic [31:0] fillAddr, missCnt, hitCnt;
  logic        stall2, fill2, busy2;
  logic [31:0] fa2;
  logic [1:0]  miss2, hit2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_refill_ctrl dut (
    .clk(clk), .rst(rst), .memReadM(rd), .memWriteM(wr), .hitM(hit), .aluResultM(addr),
    .stallM(stallM), .fillEn(fillEn), .fillAddr(fillAddr), .busy(busy),
    .missCnt(missCnt), .hitCnt(hitCnt)
  );

  // Narrow-counter copy on the same stimulus to reach saturation quickly.
  mem_refill_ctrl #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .memReadM(rd), .memWriteM(wr), .hitM(hit), .aluResultM(addr),
    .stallM(stall2), .fillEn(fill2), .fillAddr(fa2), .busy(busy2),
    .missCnt(miss2), .hitCnt(hit2)
  );

  typedef struct {
    string       tag;
    logic        stall, fill, busy;
    int          miss, hits, miss2;
    logic [31:0] fa;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      if (!$isunknown(m_e.stall)) chk({m_e.tag, ".stallM"}, {31'd0, stallM}, {31'd0, m_e.stall});
      chk({m_e.tag, ".fillEn"}, {31'd0, fillEn}, {31'd0, m_e.fill});
      chk({m_e.tag, ".busy"}, {31'd0, busy}, {31'd0, m_e.busy});
      chk({m_e.tag, ".fillAddr"}, fillAddr, m_e.fa);
      chk({m_e.tag, ".missCnt"}, missCnt, 32'(m_e.miss));
      chk({m_e.tag, ".hitCnt"}, hitCnt, 32'(m_e.hits));
      chk({m_e.tag, ".missCnt2"}, {30'd0, miss2}, 32'(m_e.miss2));
    end
  end

  task automatic cyc(input string tag, input logic rs, r, w, h, input logic [31:0] a,
                     input logic es, ef, eb, input int em, eh, em2, input logic [31:0] efa);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rs; rd = r; wr = w; hit = h; addr = a;
    e.tag = tag; e.stall = es; e.fill = ef; e.busy = eb;
    e.miss = em; e.hits = eh; e.miss2 = em2; e.fa = efa;
    exp_q.push_back(e);
  endtask

  // Load miss with READ_LATENCY=4: 5 stall cycles, fill in the 5th, then replay and idle.
  task automatic miss_seq(input string tag, input logic [31:0] a, input logic [31:0] prev_fa,
                          input logic [31:0] blk, input int m, h, m2, m2n);
    cyc(tag, 0, 1, 0, 0, a, 1, 0, 0, m,     h, m2,  prev_fa);
    cyc(tag, 0, 1, 0, 0, a, 1, 0, 1, m + 1, h, m2n, blk);
    cyc(tag, 0, 1, 0, 0, a, 1, 0, 1, m + 1, h, m2n, blk);
    cyc(tag, 0, 1, 0, 0, a, 1, 0, 1, m + 1, h, m2n, blk);
    cyc(tag, 0, 1, 0, 0, a, 1, 1, 1, m + 1, h, m2n, blk);
    cyc(tag, 0, 1, 0, 1, a, 0, 0, 1, m + 1, h, m2n, blk);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, m + 1, h, m2n, blk);
  endtask

  initial begin
    repeat (3) cyc("reset", 1, 1, 0, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 32'h0);

    miss_seq("miss1", 32'h0000_1234, 32'h0, 32'h0000_1230, 0, 0, 0, 1);

    cyc("hits", 0, 1, 0, 1, 32'h100, 0, 0, 0, 1, 0, 1, 32'h1230);
    cyc("hits", 0, 1, 0, 1, 32'h104, 0, 0, 0, 1, 1, 1, 32'h1230);
    cyc("hits", 0, 1, 0, 1, 32'h108, 0, 0, 0, 1, 2, 1, 32'h1230);
    cyc("hits", 0, 0, 0, 0, 32'h0,   0, 0, 0, 1, 3, 1, 32'h1230);

    cyc("store", 0, 0, 1, 0, 32'h200, 1, 0, 0, 1, 3, 1, 32'h1230);
    cyc("store", 0, 0, 1, 0, 32'h200, 0, 0, 1, 1, 3, 1, 32'h1230);
    cyc("store", 0, 0, 0, 0, 32'h0,   0, 0, 0, 1, 3, 1, 32'h1230);

    cyc("st_rd", 0, 1, 1, 0, 32'h300, 1, 0, 0, 1, 3, 1, 32'h1230);
    cyc("st_rd", 0, 1, 1, 0, 32'h300, 0, 0, 1, 1, 3, 1, 32'h1230);
    cyc("st_rd", 0, 0, 0, 0, 32'h0,   0, 0, 0, 1, 3, 1, 32'h1230);

    cyc("abort", 0, 1, 0, 0, 32'h48, 1,    0, 0, 1, 3, 1, 32'h1230);
    cyc("abort", 0, 1, 0, 0, 32'h48, 1,    0, 1, 2, 3, 2, 32'h48);
    cyc("abort", 1, 1, 0, 0, 32'h48, 1'bx, 0, 1, 2, 3, 2, 32'h48);
    cyc("abort", 0, 0, 0, 0, 32'h0,  0,    0, 0, 0, 0, 0, 32'h0);
    repeat (4) cyc("abort", 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0);

    miss_seq("sat", 32'h0000_1008, 32'h0,         32'h0000_1008, 0, 0, 0, 1);
    miss_seq("sat", 32'h0000_2017, 32'h0000_1008, 32'h0000_2010, 1, 0, 1, 2);
    miss_seq("sat", 32'h0000_300f, 32'h0000_2010, 32'h0000_3008, 2, 0, 2, 3);
    miss_seq("sat", 32'h0000_4001, 32'h0000_3008, 32'h0000_4000, 3, 0, 3, 3);
    miss_seq("sat", 32'hffff_fffd, 32'h0000_4000, 32'hffff_fff8, 4, 0, 3, 3);

    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
